// File: rtl/mux_nto1_reg_if.sv
// Handshake bundle for mux_nto1_reg: N input channels with per-channel valid/ready
// and one registered output channel. Driver side is master, the mux is slave.
interface mux_nto1_reg_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [SEL_W-1:0]        sl;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output sl, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  sl, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_nto1_reg.sv
// Registered N:1 multiplexer with valid/ready handshake, 1-cycle latency, full throughput.
// Define MUX_RR_EN to replace the external select with a round-robin arbiter over in_valid.
module mux_nto1_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_nto1_reg_if.slave    bus
);

  logic                    load_en;
  logic                    grant_vld;
  logic [SEL_W-1:0]        grant_idx;
  logic                    grant_in_vld;
  logic [WIDTH-1:0]        grant_data;
  logic                    xfer;
  logic [NUM_IN-1:0]       in_ready;

  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [SEL_W-1:0]        out_sel_q, out_sel_d;
  logic                    out_valid_q, out_valid_d;

  assign load_en = !out_valid_q || bus.out_ready;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hi_vld, lo_vld;
  logic [SEL_W-1:0] hi_idx, lo_idx;
  logic             unused_sl;

  assign unused_sl = ^bus.sl;

  // Lowest valid index at/above the pointer wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.in_valid[i]) begin
        if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = SEL_W'(i);
        end
        if (!hi_vld && (i >= 32'(rr_ptr_q))) begin
          hi_vld = 1'b1;
          hi_idx = SEL_W'(i);
        end
      end
    end
    grant_vld = hi_vld || lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (32'(grant_idx) + 32'd1 >= 32'(NUM_IN)) rr_ptr_d = '0;
      else                                       rr_ptr_d = grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign grant_vld = 32'(bus.sl) < 32'(NUM_IN);
  assign grant_idx = bus.sl;
`endif

  always_comb begin
    grant_in_vld = 1'b0;
    grant_data   = '0;
    in_ready     = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(grant_idx) == i) begin
        grant_in_vld = bus.in_valid[i];
        grant_data   = bus.in_data[i*WIDTH +: WIDTH];
        in_ready[i]  = grant_vld && load_en;
      end
    end
  end

  assign xfer = grant_vld && load_en && grant_in_vld;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule
